// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 opcode classes, forwarding encodings and hazard scoreboard types
package rv32_pkg;

    // Opcode bits [6:2]
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
        logic       is_store;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    typedef enum logic {
        ST_RUN,
        ST_MEMWAIT
    } hz_state_t;

    // EX beats MEM; wr is already cleared for rd == x0, so x0 never forwards
    function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                           input sb_entry_t ex, input sb_entry_t mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_rs && ex.valid && ex.wr && (ex.rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (use_rs && mem.valid && mem.wr && (mem.rd == rs)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard controller
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             br_taken;
    logic             dmem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_instr, id_valid, br_taken, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, stall, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_instr, id_valid, br_taken, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, stall, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hz_classify.sv
// rtl/hz_classify.sv - decode of the ID instruction into register-use and class flags
module hz_classify
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output logic        known,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        wr,
    output logic        is_load,
    output logic        is_store,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);
    logic [4:0] opcode;
    logic       writes;
    logic       unused_bits;

    assign opcode      = instr[6:2];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign rd          = instr[11:7];
    assign unused_bits = ^{instr[31:25], instr[14:12], instr[1:0]};

    // Opcode class table; unknown opcodes and bubbles decode to nothing
    always_comb begin
        known    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        writes   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        if (valid) begin
            case (opcode)
                OP_R:      begin known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes = 1'b1; end
                OP_STORE:  begin known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_store = 1'b1; end
                OP_BRANCH: begin known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OP_IMM:    begin known = 1'b1; uses_rs1 = 1'b1; writes = 1'b1; end
                OP_LOAD:   begin known = 1'b1; uses_rs1 = 1'b1; writes = 1'b1; is_load = 1'b1; end
                OP_JALR:   begin known = 1'b1; uses_rs1 = 1'b1; writes = 1'b1; end
                OP_LUI, OP_AUIPC, OP_JAL: begin known = 1'b1; writes = 1'b1; end
                default:   known = 1'b0;
            endcase
        end
    end

    assign wr = writes && (rd != 5'd0);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use, flush and memory-freeze control for the 5-stage core
module hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hz
);
    logic       cls_known, cls_rs1, cls_rs2, cls_wr, cls_load, cls_store;
    logic [4:0] cls_rs1_idx, cls_rs2_idx, cls_rd;

    sb_entry_t  ex_q, mem_q, wb_q, id_entry;
    hz_state_t  state_q, state_d;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0] cnt_q;

    logic load_use, mem_ls, freeze;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, stall;
    logic unused_wb;

    hz_classify u_classify (
        .instr    (hz.id_instr),
        .valid    (hz.id_valid),
        .known    (cls_known),
        .uses_rs1 (cls_rs1),
        .uses_rs2 (cls_rs2),
        .wr       (cls_wr),
        .is_load  (cls_load),
        .is_store (cls_store),
        .rs1      (cls_rs1_idx),
        .rs2      (cls_rs2_idx),
        .rd       (cls_rd)
    );

    assign id_entry  = '{valid: cls_known, rd: cls_rd, wr: cls_wr, is_load: cls_load, is_store: cls_store};
    assign fwd_a_d   = fwd_sel(cls_rs1, cls_rs1_idx, ex_q, mem_q);
    assign fwd_b_d   = fwd_sel(cls_rs2, cls_rs2_idx, ex_q, mem_q);
    assign load_use  = ex_q.valid && ex_q.is_load && ex_q.wr &&
                       ((cls_rs1 && (cls_rs1_idx == ex_q.rd)) || (cls_rs2 && (cls_rs2_idx == ex_q.rd)));
    // The MEM entry is held during a freeze, so this stays true until memory answers
    assign mem_ls    = mem_q.valid && (mem_q.is_load || mem_q.is_store);
    assign freeze    = mem_ls && !hz.dmem_ready;
    assign unused_wb = ^wb_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline control: reset > freeze > flush > load-use > advance
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall      = 1'b0;
        case (state_q)
            ST_RUN:     if (freeze) state_d = ST_MEMWAIT;
            ST_MEMWAIT: if (hz.dmem_ready) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
        if (!rst_n) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            stall = 1'b1;
        end else if (hz.br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall      = 1'b1;
        end
    end

    // Scoreboard shift, registered forwarding selects and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q    <= SB_BUBBLE;
            mem_q   <= SB_BUBBLE;
            wb_q    <= SB_BUBBLE;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (!freeze) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= idex_flush ? SB_BUBBLE : id_entry;
            end
            if (idex_en) begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.idex_en    = idex_en;
    assign hz.exmem_en   = exmem_en;
    assign hz.memwb_en   = memwb_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    assign hz.stall      = stall;
    assign hz.fwd_a      = fwd_a_q;
    assign hz.fwd_b      = fwd_b_q;
    assign hz.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int    tag;
        int    ctl;
        int    fwd;
        int    cnt;
        string name;
    } exp_t;

    exp_t exp_q[$];

    hazard_ctrl_if #(.CNT_W(16)) bus ();

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ctl nibbles: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, stall}
    localparam int C_RUN = 'hF8;
    localparam int C_RST = 'h06;
    localparam int C_FRZ = 'h01;
    localparam int C_FLS = 'hFE;
    localparam int C_LU  = 'h3B;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [6:0] f7);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd4, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction

    task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic br,
                        input logic rdy, input int ctl, input int fwd, input int cnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = r;
        bus.id_instr   = ins;
        bus.id_valid   = v;
        bus.br_taken   = br;
        bus.dmem_ready = rdy;
        e.tag  = cyc;
        e.ctl  = ctl;
        e.fwd  = fwd;
        e.cnt  = cnt;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: pop every expectation due this cycle and compare on the falling edge
    always @(negedge clk) begin
        int act_ctl, act_fwd, act_cnt;
        exp_t e;
        act_ctl = int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                        bus.ifid_flush, bus.idex_flush, bus.stall});
        act_fwd = int'({bus.fwd_a, bus.fwd_b});
        act_cnt = int'(bus.stall_cnt);
        while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.tag != cyc) begin
                errors++;
                $display("FAIL %s missed sample cycle actual=%0d required=%0d", e.name, cyc, e.tag);
            end
            if (e.ctl >= 0) begin
                checks++;
                if (act_ctl != e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl actual=%02h required=%02h (cycle %0d)", e.name, act_ctl, e.ctl, cyc);
                end
            end
            if (e.fwd >= 0) begin
                checks++;
                if (act_fwd != e.fwd) begin
                    errors++;
                    $display("FAIL %s fwd_ab actual=%04b required=%04b (cycle %0d)", e.name, act_fwd[3:0], e.fwd[3:0], cyc);
                end
            end
            if (e.cnt >= 0) begin
                checks++;
                if (act_cnt != e.cnt) begin
                    errors++;
                    $display("FAIL %s stall_cnt actual=%0d required=%0d (cycle %0d)", e.name, act_cnt, e.cnt, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nop;
        nop = 32'd0;
        bus.id_instr   = 32'd0;
        bus.id_valid   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.dmem_ready = 1'b1;

        step(0, nop, 0, 0, 1, C_RST, 0, 0, "reset_hold");
        step(0, nop, 0, 0, 1, C_RST, 0, 0, "reset_hold2");
        step(1, nop, 0, 0, 1, C_RUN, 0, 0, "reset_release");
        // back-to-back ALU
        step(1, enc_r(5, 1, 2, 7'h00), 1, 0, 1, C_RUN, 0, 0, "add_x5");
        step(1, enc_r(6, 5, 3, 7'h20), 1, 0, 1, C_RUN, 0, 0, "sub_x6");
        step(1, nop, 0, 0, 1, C_RUN, 8, 0, "b2b_alu");
        // one-apart dependency, then the same with rd = x0
        step(1, enc_i(7'b0010011, 7, 0), 1, 0, 1, C_RUN, 0, 0, "addi_x7");
        step(1, nop, 0, 0, 1, C_RUN, 0, 0, "gap1");
        step(1, enc_r(8, 2, 7, 7'h00), 1, 0, 1, C_RUN, 0, 0, "or_x8");
        step(1, enc_i(7'b0010011, 0, 0), 1, 0, 1, C_RUN, 3, 0, "one_apart");
        step(1, nop, 0, 0, 1, C_RUN, 0, 0, "gap2");
        step(1, enc_r(8, 2, 0, 7'h00), 1, 0, 1, C_RUN, 0, 0, "or_x0src");
        step(1, nop, 0, 0, 1, C_RUN, 0, 0, "x0_rd");
        // load-use
        step(1, enc_i(7'b0000011, 9, 1), 1, 0, 1, C_RUN, 0, 0, "lw_x9");
        step(1, enc_r(10, 9, 9, 7'h00), 1, 0, 1, C_LU, 0, 0, "lu_stall");
        step(1, enc_r(10, 9, 9, 7'h00), 1, 0, 1, C_RUN, -1, 1, "lu_cnt");
        step(1, nop, 0, 0, 1, C_RUN, 15, 1, "lu_fwd");
        // taken branch coinciding with load-use
        step(1, enc_i(7'b0000011, 11, 1), 1, 0, 1, C_RUN, 0, 1, "lw_x11");
        step(1, enc_r(12, 11, 0, 7'h00), 1, 1, 1, C_FLS, 0, 1, "br_over_lu");
        step(1, nop, 0, 0, 1, C_RUN, -1, 1, "post_flush");
        // store freeze with a pending branch
        step(1, enc_s(1, 2), 1, 0, 1, C_RUN, 0, 1, "sw_id");
        step(1, nop, 0, 0, 1, C_RUN, 0, 1, "sw_ex");
        step(1, nop, 0, 1, 0, C_FRZ, 0, 1, "freeze1");
        step(1, nop, 0, 1, 0, C_FRZ, 0, 2, "freeze2");
        step(1, nop, 0, 1, 0, C_FRZ, 0, 3, "freeze3");
        step(1, nop, 0, 1, 1, C_FLS, 0, 4, "freeze_release");
        step(1, nop, 0, 0, 1, C_RUN, 0, 4, "after_release");
        // reset in the middle of a freeze
        step(1, enc_s(1, 2), 1, 0, 1, C_RUN, 0, 4, "sw2_id");
        step(1, nop, 0, 0, 1, C_RUN, 0, 4, "sw2_ex");
        step(1, nop, 0, 0, 0, C_FRZ, 0, 4, "freeze_b1");
        step(1, nop, 0, 0, 0, C_FRZ, 0, 5, "freeze_b2");
        step(0, nop, 0, 0, 0, C_RST, 0, 6, "reset_midfreeze_low");
        step(1, nop, 0, 0, 0, C_RUN, 0, 0, "reset_midfreeze");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
